// File: rtl/cpu_pkg.sv
// cpu_pkg: shared select codes, select type and default widths for the ALU B-operand path
package cpu_pkg;
    typedef logic [2:0] src_b_sel_t;
    localparam src_b_sel_t SRC_B_REG      = 3'd0;
    localparam src_b_sel_t SRC_B_INC      = 3'd1;
    localparam src_b_sel_t SRC_B_SEXT     = 3'd2;
    localparam src_b_sel_t SRC_B_SEXT_SL2 = 3'd3;
    localparam src_b_sel_t SRC_B_ZEXT     = 3'd4;
    localparam int CPU_DATA_W = 32;
    localparam int CPU_IMM_W  = 16;
endpackage

// File: rtl/alu_src_b_pipe_if.sv
// alu_src_b_pipe_if: operand request/response bundle between control unit and the B-operand pipe
interface alu_src_b_pipe_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int IMM_W  = CPU_IMM_W
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    src_b_sel_t        src_sel;
    logic [DATA_W-1:0] b_in;
    logic [IMM_W-1:0]  imm_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              sel_err;
    modport master (
        output flush, in_valid, src_sel, b_in, imm_in, out_ready,
        input  in_ready, out_valid, out_data, sel_err
    );
    modport slave (
        input  flush, in_valid, src_sel, b_in, imm_in, out_ready,
        output in_ready, out_valid, out_data, sel_err
    );
endinterface

// File: rtl/alu_src_b_decode.sv
// alu_src_b_decode: combinational select/extend stage building the ALU B operand
module alu_src_b_decode
    import cpu_pkg::*;
#(
    parameter int DATA_W    = CPU_DATA_W,
    parameter int IMM_W     = CPU_IMM_W,
    parameter int INC_CONST = 4
) (
    input  src_b_sel_t        sel_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [IMM_W-1:0]  imm_i,
    output logic [DATA_W-1:0] operand_o
);
    logic [DATA_W-1:0] sext;
    // Pick the operand; codes above SRC_B_ZEXT yield zero
    always_comb begin
        sext      = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
        operand_o = sel_i == SRC_B_REG      ? b_i :
                    sel_i == SRC_B_INC      ? DATA_W'(INC_CONST) :
                    sel_i == SRC_B_SEXT     ? sext :
                    sel_i == SRC_B_SEXT_SL2 ? {sext[DATA_W-3:0], 2'b00} :
                    sel_i == SRC_B_ZEXT     ? {{(DATA_W-IMM_W){1'b0}}, imm_i} :
                                              '0;
    end
endmodule

// File: rtl/alu_src_b_pipe.sv
// alu_src_b_pipe: registered ALU B-operand selector with a 1..2 entry skid buffer
// Optional illegal-select sticky flag enabled by defining ALU_SRC_B_SELCHK_EN.
module alu_src_b_pipe
    import cpu_pkg::*;
#(
    parameter int DATA_W    = CPU_DATA_W,
    parameter int IMM_W     = CPU_IMM_W,
    parameter int INC_CONST = 4,
    parameter int DEPTH     = 2
) (
    input logic               clk,
    input logic               reset,
    alu_src_b_pipe_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [CW-1:0]     count_q, count_d, wr_idx;
    logic              push, pop;
    alu_src_b_decode #(
        .DATA_W    (DATA_W),
        .IMM_W     (IMM_W),
        .INC_CONST (INC_CONST)
    ) u_decode (
        .sel_i     (bus.src_sel),
        .b_i       (bus.b_in),
        .imm_i     (bus.imm_in),
        .operand_o (operand)
    );
    assign bus.in_ready  = count_q < CW'(DEPTH);
    assign bus.out_valid = count_q != '0;
    assign bus.out_data  = mem_q[0];
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;
    assign wr_idx        = count_q - CW'(pop);
    // Next buffer contents: head only advances when a younger entry exists, so it holds its last value when empty
    always_comb begin
        mem_d   = mem_q;
        count_d = bus.flush ? '0 : count_q + CW'(push) - CW'(pop);
        if (!bus.flush) begin
            for (int i = 0; i < DEPTH - 1; i++)
                if (pop && count_q > CW'(1)) mem_d[i] = mem_q[i+1];
            for (int i = 0; i < DEPTH; i++)
                if (push && wr_idx == CW'(i)) mem_d[i] = operand;
        end
    end
    // Buffer and occupancy registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q   <= '{default: '0};
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end
`ifdef ALU_SRC_B_SELCHK_EN
    logic sel_err_q, sel_err_d;
    assign sel_err_d   = sel_err_q || (push && bus.src_sel > SRC_B_ZEXT);
    assign bus.sel_err = sel_err_q;
    // Sticky illegal-select flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!reset) sel_err_q <= 1'b0;
        else        sel_err_q <= sel_err_d;
    end
`else
    assign bus.sel_err = 1'b0;
`endif
endmodule

// File: doc/alu_src_b_pipe.md
Name: alu_src_b_pipe

Overview:
- Parametrised, registered successor to the ALU second-operand selector of the multicycle CPU.
- Builds the ALU B operand from five sources:
  - B register
  - increment constant (PC+4 path)
  - sign-extended immediate
  - sign-extended immediate shifted left 2 (branch offset)
  - zero-extended immediate (logical ops)
- Queues results in a 2-entry skid buffer with valid/ready handshake, so the control unit can stall the ALU without losing an operand.

Parameters:
- DATA_W, 32, operand and output width.
- IMM_W, 16, immediate width; must be <= DATA_W-2.
- INC_CONST, 4, value driven for select code 1.
- DEPTH, 2, skid buffer entries; legal values are 1 or 2.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  synchronous clear of buffered entries.
- in_valid  in  1  source operands and select are valid this cycle.
- in_ready  out  1  buffer can accept an entry.
- src_sel  in  3  operand select code.
- b_in  in  DATA_W  B register value.
- imm_in  in  IMM_W  raw instruction immediate.
- out_valid  out  1  out_data holds a valid operand.
- out_ready  in  1  ALU consumes out_data this cycle.
- out_data  out  DATA_W  selected operand, head of buffer.
- sel_err  out  1  sticky illegal-select flag (see Optional Feature).

Behaviour:
- Select decode (combinational, before buffer):
  - 0 = b_in
  - 1 = INC_CONST zero-extended to DATA_W
  - 2 = sign-extend(imm_in)
  - 3 = sign-extend(imm_in) << 2, upper bits dropped, bits [1:0] = 0
  - 4 = zero-extend(imm_in)
  - 5..7 = illegal, operand value 0
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count < DEPTH); it is combinational from count only, never from out_ready.
- out_valid = (count != 0); out_data = head entry. When count == 0, out_data holds its last value (0 after reset).
- Latency: an operand pushed in cycle N is on out_data with out_valid = 1 in cycle N+1. There is no combinational path from input to output.
- Ordering: strict FIFO.
- Boundary cases:
  - count == 1, push and pop in the same cycle: count stays 1; the new entry becomes head in N+1.
  - count == DEPTH: in_ready = 0, so a push is impossible; a pop frees a slot visible in the next cycle.
  - count == 0 with pop requested: pop is impossible (out_valid = 0); no change.
  - flush: count is 0 next cycle, and any push in the same cycle is discarded. flush takes priority over push and pop. out_data is not cleared.
- Reset (reset == 0 at a clock edge):
  - count = 0, all entries = 0, out_data = 0, out_valid = 0, in_ready = 1, sel_err = 0.
  - Reset wins over flush, push and pop.
  - Reset mid-stream discards all entries.
- in_valid is not required to be held; src_sel is sampled only on a push.

Optional Feature:
- Macro: ALU_SRC_B_SELCHK_EN.
- Defined:
  - sel_err is set in the cycle after a push with src_sel in 5..7.
  - It stays set until reset; flush does not clear it.
  - The illegal entry is still pushed with value 0.
- Undefined:
  - sel_err is tied to 0.
  - Illegal codes still produce value 0.
  - No checking logic is synthesised.

Decomposition:
- Shared package cpu_pkg:
  - select-code constants SRC_B_REG, SRC_B_INC, SRC_B_SEXT, SRC_B_SEXT_SL2, SRC_B_ZEXT
  - typedef for the 3-bit select
  - default DATA_W / IMM_W constants
- Sub-module alu_src_b_decode: the pure combinational select/extend stage.
- The top level owns the skid buffer and count.

Test Plan:
- Reset then push src_sel = 0, b_in = 0x0000_00AA, out_ready = 1 -> out_data = 0x0000_00AA, out_valid = 1 the next cycle only.
- Push src_sel = 3, imm_in = 0xFFFE -> out_data = 0xFFFF_FFF8. Push src_sel = 2, imm_in = 0x8000 -> 0xFFFF_8000. Push src_sel = 4, imm_in = 0x8000 -> 0x0000_8000. Push src_sel = 1 -> 0x0000_0004.
- out_ready = 0, push 3 back-to-back values 1, 2, 3 -> in_ready drops after 2 pushes and value 3 is not accepted. Then out_ready = 1 -> pops 1, 2 in order, then in_ready = 1.
- count = 1 (value 0x10 buffered), push 0x20 with out_ready = 1 in the same cycle -> 0x10 consumed, count stays 1, out_data = 0x20 next cycle.
- count = 2, assert flush together with in_valid = 1 -> next cycle out_valid = 0, count = 0, pushed value discarded. Separately, reset = 0 mid-stream -> all outputs at reset values next cycle.
- With ALU_SRC_B_SELCHK_EN: push src_sel = 6 -> out_data = 0 and sel_err = 1 next cycle; sel_err stays 1 through flush and clears only on reset. Without the macro, sel_err stays 0.
